// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding and memory sizing.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HI      = 3'd1,
    ST_LO      = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int MEM_DEPTH = 256;
  localparam int MAX_WORDS = 256;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: packs byte pairs into words, writes them to the
// datapath memory, then hands memory back and releases the processor reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [8:0]        word_count,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] Tb_MEMAddr,
  output logic [DATA_W-1:0] Tb_MEMData,
  output logic              Tb_MEMWE,
  output logic              TBorNot,
  output logic              CPU_Rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   ptr_r, ptr_nxt_s;
  logic [8:0]          remaining_r, remaining_nxt_s;
  logic [7:0]          hi_byte_r, hi_byte_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [DATA_W-1:0]   data_r, data_nxt_s;
  logic                we_r, we_nxt_s;
  logic                tb_own_r, tb_own_nxt_s;
  logic                cpu_rst_r, cpu_rst_nxt_s;
  logic                err_r, err_nxt_s;
  logic                ready_r, ready_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                done_r, done_nxt_s;
  logic                start_ok_s;
  logic                xfer_s;

  assign start_ok_s = start && (word_count != 9'd0) && (word_count <= 9'(MAX_WORDS));
  assign xfer_s     = in_valid && ready_r;

  // Next-state decode of the load sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:    if (start_ok_s) state_nxt_s = ST_HI; else state_nxt_s = ST_IDLE;
      ST_HI:      if (xfer_s) state_nxt_s = ST_LO; else state_nxt_s = ST_HI;
      ST_LO:      if (xfer_s) state_nxt_s = ST_WRITE; else state_nxt_s = ST_LO;
      ST_WRITE:   if (remaining_r == 9'd1) state_nxt_s = ST_RELEASE; else state_nxt_s = ST_HI;
      ST_RELEASE: state_nxt_s = ST_DONE;
      ST_DONE:    if (start_ok_s) state_nxt_s = ST_HI; else state_nxt_s = ST_DONE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the datapath and output registers.
  always_comb begin
    ptr_nxt_s       = ptr_r;
    remaining_nxt_s = remaining_r;
    hi_byte_nxt_s   = hi_byte_r;
    addr_nxt_s      = addr_r;
    data_nxt_s      = data_r;
    we_nxt_s        = 1'b0;
    tb_own_nxt_s    = tb_own_r;
    cpu_rst_nxt_s   = cpu_rst_r;
    err_nxt_s       = err_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        // The processor runs in DONE until a legal start reclaims memory.
        if (state_r == ST_DONE) cpu_rst_nxt_s = 1'b0; else cpu_rst_nxt_s = cpu_rst_r;
        if (start_ok_s) begin
          ptr_nxt_s       = ADDR_W'(START_ADDR);
          remaining_nxt_s = word_count;
          tb_own_nxt_s    = 1'b1;
          cpu_rst_nxt_s   = 1'b1;
          err_nxt_s       = 1'b0;
        end else if (start) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
      end
      ST_HI: begin
        if (xfer_s) hi_byte_nxt_s = in_byte; else hi_byte_nxt_s = hi_byte_r;
      end
      ST_LO: begin
        if (xfer_s) begin
          data_nxt_s = {hi_byte_r, in_byte};
          addr_nxt_s = ptr_r;
          we_nxt_s   = 1'b1;
        end else begin
          we_nxt_s = 1'b0;
        end
      end
      ST_WRITE: begin
        ptr_nxt_s       = ptr_r + ADDR_W'(1);
        remaining_nxt_s = remaining_r - 9'd1;
      end
      ST_RELEASE: tb_own_nxt_s = 1'b0;
      default: begin
        we_nxt_s = 1'b0;
      end
    endcase
    ready_nxt_s = (state_nxt_s == ST_HI) || (state_nxt_s == ST_LO);
    busy_nxt_s  = (state_nxt_s == ST_HI) || (state_nxt_s == ST_LO) ||
                  (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_RELEASE);
    done_nxt_s  = (state_nxt_s == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= ADDR_W'(START_ADDR);
      remaining_r <= 9'd0;
      hi_byte_r   <= 8'd0;
      addr_r      <= '0;
      data_r      <= '0;
      we_r        <= 1'b0;
      tb_own_r    <= 1'b1;
      cpu_rst_r   <= 1'b1;
      err_r       <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      remaining_r <= remaining_nxt_s;
      hi_byte_r   <= hi_byte_nxt_s;
      addr_r      <= addr_nxt_s;
      data_r      <= data_nxt_s;
      we_r        <= we_nxt_s;
      tb_own_r    <= tb_own_nxt_s;
      cpu_rst_r   <= cpu_rst_nxt_s;
      err_r       <= err_nxt_s;
      ready_r     <= ready_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  assign in_ready   = ready_r;
  assign Tb_MEMAddr = addr_r;
  assign Tb_MEMData = data_r;
  assign Tb_MEMWE   = we_r;
  assign TBorNot    = tb_own_r;
  assign CPU_Rst    = cpu_rst_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: two instances (START_ADDR 0 and 254)
// share stimulus; a write scoreboard checks every memory write pulse.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       Rst;
  logic       start;
  logic [8:0] word_count;
  logic [7:0] in_byte;
  logic       in_valid;

  logic       in_ready0, we0, tb0, cpu0, busy0, done0, err0;
  logic [7:0] addr0;
  logic [15:0] data0;
  logic       in_ready1, we1, tb1, cpu1, busy1, done1, err1;
  logic [7:0] addr1;
  logic [15:0] data1;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(8), .DATA_W(16), .START_ADDR(0)) dut0 (
    .clk(clk), .Rst(Rst), .start(start), .word_count(word_count),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready0),
    .Tb_MEMAddr(addr0), .Tb_MEMData(data0), .Tb_MEMWE(we0),
    .TBorNot(tb0), .CPU_Rst(cpu0), .busy(busy0), .done(done0), .err(err0));

  prog_loader #(.ADDR_W(8), .DATA_W(16), .START_ADDR(254)) dut1 (
    .clk(clk), .Rst(Rst), .start(start), .word_count(word_count),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready1),
    .Tb_MEMAddr(addr1), .Tb_MEMData(data1), .Tb_MEMWE(we1),
    .TBorNot(tb1), .CPU_Rst(cpu1), .busy(busy1), .done(done1), .err(err1));

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt0 = 0;
  int we_cnt1 = 0;

  typedef struct packed {
    logic [7:0]  off;
    logic [15:0] data;
  } wr_t;
  wr_t q0[$];
  wr_t q1[$];
  wr_t e0, e1;

  logic [7:0] tx [0:15];
  bit         vpat [0:7];
  int         vpat_len;

  typedef struct {
    logic [8:0] wc;
    logic       exp_err;
    logic       exp_busy;
    logic       exp_ready;
  } vec_t;
  vec_t vecs [0:5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write scoreboard: every WE pulse must match the next expected word.
  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      we_cnt0++;
      chk("we0_owner", 32'(tb0), 32'd1);
      if (q0.size() == 0) chk("we0_unexpected", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        chk("addr0", 32'(addr0), 32'(e0.off));
        chk("data0", 32'(data0), 32'(e0.data));
      end
    end
    if (we1 === 1'b1) begin
      we_cnt1++;
      chk("we1_owner", 32'(tb1), 32'd1);
      if (q1.size() == 0) chk("we1_unexpected", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("addr1", 32'(addr1), 32'(8'(8'd254 + e1.off)));
        chk("data1", 32'(data1), 32'(e1.data));
      end
    end
  end

  task automatic expect_words(input int n);
    wr_t w;
    for (int k = 0; k < n; k++) begin
      w.off  = 8'(k);
      w.data = {tx[2*k], tx[2*k+1]};
      q0.push_back(w);
      q1.push_back(w);
    end
  endtask

  // Called at a negedge; one posedge with Rst high.
  task automatic do_reset();
    Rst = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
  endtask

  task automatic do_start(input logic [8:0] wc);
    start = 1'b1;
    word_count = wc;
    @(negedge clk);
    start = 1'b0;
    word_count = 9'd0;
  endtask

  task automatic send_bytes(input int n);
    int  idx = 0;
    int  cyc = 0;
    logic rdy;
    while (idx < n && cyc < 200) begin
      in_valid = vpat[cyc % vpat_len];
      in_byte  = in_valid ? tx[idx] : 8'hEE;
      rdy = in_ready0;
      @(posedge clk);
      if (in_valid && rdy) idx++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("send_complete", 32'(idx), 32'(n));
  endtask

  task automatic check_reset_vals();
    chk("rst_tb",    32'({tb0, tb1}),       32'd3);
    chk("rst_cpu",   32'({cpu0, cpu1}),     32'd3);
    chk("rst_we",    32'({we0, we1}),       32'd0);
    chk("rst_addr",  32'({addr0, addr1}),   32'd0);
    chk("rst_data",  32'({data0, data1}),   32'd0);
    chk("rst_ready", 32'({in_ready0, in_ready1}), 32'd0);
    chk("rst_flags", 32'({busy0, done0, err0, busy1, done1, err1}), 32'd0);
  endtask

  int base0, base1;

  initial begin
    Rst = 1'b1; start = 1'b0; word_count = 9'd0; in_byte = 8'd0; in_valid = 1'b0;
    vpat_len = 1; vpat[0] = 1'b1;
    vecs[0] = '{9'd0,   1'b1, 1'b0, 1'b0};
    vecs[1] = '{9'd300, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{9'd257, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{9'd511, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{9'd1,   1'b0, 1'b1, 1'b1};
    vecs[5] = '{9'd256, 1'b0, 1'b1, 1'b1};
    repeat (2) @(negedge clk);
    do_reset();
    check_reset_vals();

    // Table: start response from IDLE for legal and illegal counts.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      base0 = we_cnt0;
      do_start(vecs[i].wc);
      chk("vec_err",   32'(err0),      32'(vecs[i].exp_err));
      chk("vec_busy",  32'(busy0),     32'(vecs[i].exp_busy));
      chk("vec_ready", 32'(in_ready0), 32'(vecs[i].exp_ready));
      chk("vec_own",   32'({tb0, cpu0, done0}), 32'b110);
      @(negedge clk);
      chk("vec_busy2", 32'(busy0), 32'(vecs[i].exp_busy));
      chk("vec_nowe",  32'(we_cnt0 - base0), 32'd0);
    end

    // Two words with in_valid held high, plus release latency.
    do_reset();
    tx[0] = 8'h12; tx[1] = 8'h34; tx[2] = 8'hAB; tx[3] = 8'hCD;
    base0 = we_cnt0; base1 = we_cnt1;
    expect_words(2);
    do_start(9'd2);
    send_bytes(4);
    chk("lat_we",   32'({we0, tb0}), 32'b11);
    @(negedge clk);
    chk("lat_rel",  32'({we0, tb0, cpu0, busy0}), 32'b0111);
    @(negedge clk);
    chk("lat_tb",   32'({tb0, cpu0, done0, busy0}), 32'b0110);
    @(negedge clk);
    chk("lat_cpu",  32'({tb0, cpu0, done0}), 32'b001);
    chk("two_cnt",  32'(we_cnt0 - base0), 32'd2);
    chk("two_q",    32'(q0.size() + q1.size()), 32'd0);

    // Three words: second instance wraps 254, 255, 0.
    do_reset();
    for (int k = 0; k < 6; k++) tx[k] = 8'(8'h40 + 8'(k * 17));
    base0 = we_cnt0; base1 = we_cnt1;
    expect_words(3);
    do_start(9'd3);
    send_bytes(6);
    repeat (4) @(negedge clk);
    chk("wrap_cnt0", 32'(we_cnt0 - base0), 32'd3);
    chk("wrap_cnt1", 32'(we_cnt1 - base1), 32'd3);
    chk("wrap_done", 32'({done1, cpu1, tb1}), 32'b100);

    // One word with in_valid toggling 1,0,0,1.
    do_reset();
    tx[0] = 8'h5A; tx[1] = 8'hC3;
    vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b0; vpat[3] = 1'b1; vpat_len = 4;
    base0 = we_cnt0;
    expect_words(1);
    do_start(9'd1);
    send_bytes(2);
    vpat_len = 1; vpat[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("tog_cnt",  32'(we_cnt0 - base0), 32'd1);
    chk("tog_done", 32'({done0, cpu0, tb0}), 32'b100);

    // In DONE: offered bytes are refused; illegal start keeps CPU running.
    in_valid = 1'b1; in_byte = 8'hEE;
    @(negedge clk);
    chk("done_noready", 32'(in_ready0), 32'd0);
    in_valid = 1'b0;
    do_start(9'd0);
    chk("done_err", 32'({err0, done0, cpu0, tb0}), 32'b1100);
    do_start(9'd1);
    chk("reload_own", 32'({tb0, cpu0, done0, err0, busy0}), 32'b11001);
    tx[0] = 8'h0F; tx[1] = 8'hF0;
    base0 = we_cnt0;
    expect_words(1);
    send_bytes(2);
    repeat (3) @(negedge clk);
    chk("reload_end", 32'({done0, cpu0, tb0}), 32'b100);
    chk("reload_cnt", 32'(we_cnt0 - base0), 32'd1);

    // Reset while in LO of the second of four words.
    do_reset();
    for (int k = 0; k < 8; k++) tx[k] = 8'(8'h11 * (k + 1));
    base0 = we_cnt0;
    expect_words(1);
    do_start(9'd4);
    send_bytes(3);
    in_valid = 1'b1; in_byte = 8'h44;
    do_reset();
    check_reset_vals();
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("abort_cnt", 32'(we_cnt0 - base0), 32'd1);
    tx[0] = 8'h9A; tx[1] = 8'hBC;
    expect_words(1);
    do_start(9'd1);
    send_bytes(2);
    repeat (3) @(negedge clk);
    chk("abort_reload", 32'(we_cnt0 - base0), 32'd2);
    chk("final_q", 32'(q0.size() + q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
